// File: rtl/npu_result_pkg.sv
// Shared types and register map for the NPU result capture block.
package npu_result_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  localparam logic [1:0] ADDR_FIFO     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_BYTE_CNT = 2'd2;
  localparam logic [1:0] ADDR_ARGMAX   = 2'd3;

  localparam int ST_OVERFLOW = 31;
  localparam int ST_DONE     = 30;
  localparam int ST_EMPTY    = 29;
  localparam int ST_FULL     = 28;
  localparam int ST_LATE_ERR = 27;

endpackage

// File: rtl/npu_result_capture_if.sv
// Result byte stream, control pulse and Avalon-MM read slave of the result capture block.
interface npu_result_capture_if;
  logic [7:0]  d_out;
  logic        d_out_valid;
  logic        clr;
  logic        chipselect;
  logic        read;
  logic [1:0]  address;
  logic [31:0] readdata;
  logic        done_irq;

  modport master (output d_out, d_out_valid, clr, chipselect, read, address,
                  input  readdata, done_irq);
  modport slave  (input  d_out, d_out_valid, clr, chipselect, read, address,
                  output readdata, done_irq);
endinterface

// File: rtl/npu_result_capture_fifo.sv
// Synchronous show-ahead FIFO; a pop while full frees the slot for a same-cycle push.
module result_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
      2'b01:   cnt_d = cnt_q - {{AW{1'b0}}, 1'b1};
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + {{(AW-1){1'b0}}, 1'b1};
      if (do_pop)  rd_q <= rd_q + {{(AW-1){1'b0}}, 1'b1};
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/npu_result_capture.sv
// Packs the NPU D_OUT byte stream into 32-bit words, buffers them and serves an Avalon read slave.
// Optional RESULT_ARGMAX_EN adds a running max/argmax tracker behind address 3.
module npu_result_capture
  import npu_result_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CLASS_CNT  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  npu_result_capture_if.slave  bus
);
  localparam int         CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] CLS = 8'(CLASS_CNT);

  state_t      state_q, state_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] pack_q, pack_d;
  logic        ovf_q, ovf_d, late_q, late_d;
  logic [31:0] rdata_q, rdata_d;

  logic        push, pop, rd_en, accept, late_byte;
  logic [31:0] push_data, head, status, argmax;
  logic [CW-1:0] fifo_count;
  logic        fifo_full, fifo_empty;

  // A byte is taken only while collecting and before the count reaches CLASS_CNT.
  assign accept    = bus.d_out_valid & ~bus.clr &
                     ((state_q == IDLE) || (state_q == COLLECT && byte_cnt_q != CLS));
  assign late_byte = bus.d_out_valid & ~bus.clr & (state_q == FLUSH || state_q == DONE);
  assign rd_en     = bus.chipselect & bus.read;
  assign pop       = rd_en & (bus.address == ADDR_FIFO) & ~fifo_empty;

  always_comb begin
    status = '0;
    status[ST_OVERFLOW] = ovf_q;
    status[ST_DONE]     = (state_q == DONE);
    status[ST_EMPTY]    = fifo_empty;
    status[ST_FULL]     = fifo_full;
    status[ST_LATE_ERR] = late_q;
    status[7:0]         = 8'(fifo_count);
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    lane_d     = lane_q;
    pack_d     = pack_q;
    ovf_d      = ovf_q;
    late_d     = late_q;
    rdata_d    = rdata_q;
    push       = 1'b0;
    push_data  = '0;

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 8'd1;
      if (lane_q == 2'd3) begin
        push      = 1'b1;
        push_data = {bus.d_out, pack_q};
        lane_d    = '0;
        pack_d    = '0;
      end else begin
        pack_d[8*lane_q +: 8] = bus.d_out;
        lane_d = lane_q + 2'd1;
      end
    end

    // Tail word is already zero-padded because lanes are cleared after every push.
    if (state_q == FLUSH) begin
      lane_d = '0;
      pack_d = '0;
      if (lane_q != 2'd0) begin
        push      = 1'b1;
        push_data = {8'h00, pack_q};
      end
    end

    case (state_q)
      IDLE:    if (accept) state_d = COLLECT;
      COLLECT: if (byte_cnt_q == CLS) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      default: state_d = state_q;
    endcase

    if (late_byte) late_d = 1'b1;

    if (rd_en) begin
      case (bus.address)
        ADDR_FIFO:     rdata_d = fifo_empty ? 32'h0 : head;
        ADDR_STATUS:   rdata_d = status;
        ADDR_BYTE_CNT: rdata_d = {24'h0, byte_cnt_q};
        default:       rdata_d = argmax;
      endcase
    end

    // clr restarts the inference; words already in the FIFO stay for the host.
    if (bus.clr) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      lane_d     = '0;
      pack_d     = '0;
      late_d     = 1'b0;
      push       = 1'b0;
    end

    if (push & fifo_full & ~pop) ovf_d = 1'b1;
    if (bus.clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      ovf_q      <= 1'b0;
      late_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      ovf_q      <= ovf_d;
      late_q     <= late_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef RESULT_ARGMAX_EN
  logic [7:0] max_val_q;
  logic [3:0] max_idx_q;

  // Strict compare keeps the lower index on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (bus.clr) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (accept && bus.d_out > max_val_q) begin
      max_val_q <= bus.d_out;
      max_idx_q <= byte_cnt_q[3:0];
    end
  end

  assign argmax = {16'h0, max_val_q, 4'h0, max_idx_q};
`else
  assign argmax = 32'h0;
`endif

  result_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.readdata = rdata_q;
  assign bus.done_irq = (state_q == DONE);
endmodule
